// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND binary-to-BCD conversion path.
package fnd_pkg;

  localparam logic [3:0] BLANK_CODE_DEFAULT = 4'd10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    FINISH = ST_FINISH
  } state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Smallest r with 2**r >= v; clog2(1) is 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_blanker.sv
// Final digit shaping: saturation to all nines and leading-zero blanking.
module bcd_blanker
  import fnd_pkg::*;
#(
  parameter int         DIGITS     = 4,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic [4*DIGITS-1:0] raw,
  input  logic                blank_en,
  input  logic                ovf,
  output logic [4*DIGITS-1:0] digits
);

  logic [4*DIGITS-1:0] sat;

  always_comb begin
    sat = raw;
    if (ovf) begin
      for (int i = 0; i < DIGITS; i++) begin
        sat[4*i +: 4] = 4'd9;
      end
    end
  end

  // Walk down from the top nibble; the first nonzero nibble stops blanking.
  always_comb begin
    logic leading;
    digits  = sat;
    leading = blank_en;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (sat[4*i +: 4] == 4'd0)) begin
        digits[4*i +: 4] = BLANK_CODE;
      end else begin
        leading = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_digit_converter.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
module bcd_digit_converter
  import fnd_pkg::*;
#(
  parameter int         BIN_W      = 14,
  parameter int         DIGITS     = 4,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  input  logic                blank_en,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] digits,
  output logic                overflow
);

  localparam int                SCR_W    = 4 * DIGITS;
  localparam int                CNT_W    = clog2(BIN_W) + 1;
  localparam logic [63:0]       LIMIT    = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BIN_W - 1);

  function automatic logic [SCR_W-1:0] reset_digits();
    logic [SCR_W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (i == 0) ? 4'd0 : BLANK_CODE;
    end
    return r;
  endfunction

  localparam logic [SCR_W-1:0] RESET_DIGITS = reset_digits();

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               blank_q, blank_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   digits_q, digits_d;
  logic               overflow_q, overflow_d;

  logic [SCR_W-1:0]   adjusted;
  logic [SCR_W-1:0]   shaped;
  logic               in_ovf;

  // A value that cannot exceed the limit for this BIN_W folds to constant 0.
  assign in_ovf = (64'(bin_in) > LIMIT);

  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  bcd_blanker #(
    .DIGITS     (DIGITS),
    .BLANK_CODE (BLANK_CODE)
  ) u_blanker (
    .raw      (scratch_q),
    .blank_en (blank_q),
    .ovf      (ovf_q),
    .digits   (shaped)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    blank_d    = blank_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    digits_d   = digits_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          blank_d   = blank_en;
          ovf_d     = in_ovf;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adjusted[SCR_W-2:0], shift_q, 1'b0};
        if (cnt_q == LAST_BIT) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        digits_d   = shaped;
        overflow_d = ovf_q;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      blank_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= RESET_DIGITS;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      blank_q    <= blank_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule

// File: doc/bcd_digit_converter.md
Name: bcd_digit_converter

Overview:
- Sequential, parametrised binary-to-BCD converter for the seven-segment (FND) display path.
- Generalises the two-digit speed split to DIGITS decimal digits, using iterative shift-add-3 (double dabble).
- Adds a start/busy/done handshake, optional leading-zero blanking, and overflow saturation.
- Feeds digit codes to the FND scan/decoder. Blank code BLANK_CODE is decoded downstream as "segment off".

Parameters:
BIN_W, 14, width of binary input (1..27)
DIGITS, 4, number of BCD output digits (1..8)
BLANK_CODE, 4'd10, nibble emitted for a blanked digit (must be 10..15)

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
start  in  1  request conversion; sampled only while idle
bin_in  in  BIN_W  unsigned value; latched on accepted start
blank_en  in  1  enable leading-zero blanking; latched on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse: new result valid
digits  out  4*DIGITS  nibble i = 10^i digit; nibble 0 = ones
overflow  out  1  last result saturated; held until next done

Behaviour:
- Reset (rst=1 at a clock edge, synchronous, overrides everything):
  - FSM returns to IDLE.
  - busy=0, done=0, overflow=0.
  - digits = BLANK_CODE in every nibble except nibble 0, which is 0 (e.g. 0xAAA0).
  - A conversion in progress is abandoned; no done pulse is produced.
- FSM states: IDLE -> SHIFT -> FINISH -> IDLE.
- IDLE:
  - start=1 latches bin_in, blank_en, and ovf = (bin_in > 10^DIGITS-1).
  - Clears the BCD scratch register and bit counter, then moves to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one bit per clock, exactly BIN_W cycles:
  - Every scratch nibble >= 5 gets +3.
  - Then {scratch, shift_reg} shifts left by 1, MSB first.
  - Counter reaching BIN_W-1 moves to FINISH.
- FINISH, one cycle, then IDLE:
  - If ovf: all nibbles = 9, overflow=1.
  - Else nibbles = scratch, overflow=0.
  - If blank_en: every zero nibble above the highest nonzero nibble becomes BLANK_CODE. Nibble 0 is never blanked; interior zeros are kept.
  - digits/overflow register at the FINISH edge; done=1 for exactly the following cycle.
- Timing:
  - Latency: start sampled at edge k -> done high in cycle after edge k+BIN_W+1, i.e. BIN_W+2 cycles.
  - busy=1 for cycles k+1 .. k+BIN_W+1; busy=0 in the same cycle done=1.
- start while busy: ignored, not queued.
- start in the same cycle as done: accepted, since the FSM is already in IDLE.
- Outputs hold their last result between conversions; bin_in changes while busy have no effect.
- Scratch register is 4*DIGITS bits. Overflow is detected by compare, not by carry-out. If BIN_W is too small to exceed 10^DIGITS-1, ovf is constant 0.
- Counter width: clog2(BIN_W)+1.

Decomposition:
- Package fnd_pkg:
  - BLANK_CODE default.
  - FSM state encodings (IDLE/SHIFT/FINISH as 2-bit localparams).
  - constant function pow10(n) for the overflow limit.
  - clog2 function.
- Sub-module bcd_blanker: combinational, parametrised by DIGITS.
  - Inputs: raw nibbles, blank_en, ovf.
  - Output: final digit vector, applying saturation and leading-zero blanking.
- Double-dabble core and FSM remain in the top module.

Test Plan (DIGITS=4, BIN_W=14, BLANK_CODE=10):
- Reset -> digits=0xAAA0, busy=0, done=0, overflow=0; hold rst 3 cycles, outputs stable.
- start, bin_in=1234, blank_en=1 -> busy 15 cycles, done at cycle 16, digits=0x1234, overflow=0.
- bin_in=7 with blank_en=1 -> 0xAAA7; with blank_en=0 -> 0x0007. bin_in=1005, blank_en=1 -> 0x1005. bin_in=0, blank_en=1 -> 0xAAA0.
- bin_in=12000 -> digits=0x9999, overflow=1. Next conversion bin_in=9999 -> 0x9999, overflow=0.
- start pulsed at cycles 3 and 8 of a conversion -> ignored, single done. start held high through done -> back-to-back conversions with done every 16 cycles.
- rst asserted at SHIFT cycle 6 -> idle next cycle, busy=0, no done, digits=0xAAA0. Fresh start afterwards converts 42 -> 0xAA42.
